// File: rtl/graphics_pkg.sv
// Shared types and screen constants for the triangle setup path.
package graphics_pkg;

  localparam int SCREEN_HALF_W = 160;
  localparam int SCREEN_HALF_H = 120;

  typedef struct packed {
    logic        [15:0] color;
    logic signed [15:0] p1x;
    logic signed [15:0] p1y;
    logic signed [15:0] p2x;
    logic signed [15:0] p2y;
    logic signed [15:0] p3x;
    logic signed [15:0] p3y;
    logic        [15:0] depth;
  } triangle_t;

  typedef struct packed {
    logic signed [15:0] xmin;
    logic signed [15:0] xmax;
    logic signed [15:0] ymin;
    logic signed [15:0] ymax;
  } bbox_t;

  typedef struct packed {
    triangle_t triangle;
    bbox_t     bbox;
  } entry_t;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; read data is forced to zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 192,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = AW'(wptr_q + AW'(1));
    if (do_pop)  rptr_d = AW'(rptr_q + AW'(1));
    case ({do_push, do_pop})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_q ? '0 : mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/triangle_setup_fifo.sv
// Captures projected triangles, culls off-screen ones, computes a clamped
// bounding box and queues {triangle, bbox} for the rasterizer.
module triangle_setup_fifo
  import graphics_pkg::*;
#(
  parameter int          HALF_W = SCREEN_HALF_W,
  parameter int          HALF_H = SCREEN_HALF_H,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  triangle_t   triangle_in,
  input  logic        new_triangle_in,
  input  logic        done_in,
  output triangle_t   out_triangle,
  output bbox_t       out_bbox,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done_out,
  output logic [15:0] culled_count,
  output logic [15:0] dropped_count
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned FIFO_W = $bits(entry_t);
  localparam logic signed [15:0] X_LO = 16'(-HALF_W);
  localparam logic signed [15:0] X_HI = 16'(HALF_W - 1);
  localparam logic signed [15:0] Y_LO = 16'(-HALF_H);
  localparam logic signed [15:0] Y_HI = 16'(HALF_H - 1);

  triangle_t   cap_q, cap_d;
  logic        cap_valid_q, cap_valid_d;
  logic        done_pending_q, done_pending_d;
  logic        done_q, done_d;
  logic [15:0] culled_q, culled_d, dropped_q, dropped_d;

  logic signed [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic               cull_c, pop_c, push_c, done_fire_c;
  bbox_t              bbox_c;
  entry_t             wentry_c, head_c;
  logic [FIFO_W-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;

  // Bounding box and cull decision from the capture register.
  always_comb begin
    xmin_c = min3(cap_q.p1x, cap_q.p2x, cap_q.p3x);
    xmax_c = max3(cap_q.p1x, cap_q.p2x, cap_q.p3x);
    ymin_c = min3(cap_q.p1y, cap_q.p2y, cap_q.p3y);
    ymax_c = max3(cap_q.p1y, cap_q.p2y, cap_q.p3y);
    cull_c = (xmax_c < X_LO) || (xmin_c > X_HI) ||
             (ymax_c < Y_LO) || (ymin_c > Y_HI);
    bbox_c.xmin = (xmin_c < X_LO) ? X_LO : xmin_c;
    bbox_c.xmax = (xmax_c > X_HI) ? X_HI : xmax_c;
    bbox_c.ymin = (ymin_c < Y_LO) ? Y_LO : ymin_c;
    bbox_c.ymax = (ymax_c > Y_HI) ? Y_HI : ymax_c;
    wentry_c.triangle = cap_q;
    wentry_c.bbox     = bbox_c;
  end

  assign pop_c       = !fifo_empty && out_ready;
  assign push_c      = cap_valid_q && !cull_c && (!fifo_full || pop_c);
  assign done_fire_c = done_pending_q && !cap_valid_q && !new_triangle_in &&
                       (fifo_count == '0);

  always_comb begin
    cap_d          = cap_q;
    cap_valid_d    = new_triangle_in;
    culled_d       = culled_q;
    dropped_d      = dropped_q;
    done_d         = done_fire_c;
    done_pending_d = done_in || (done_pending_q && !done_fire_c);
    if (new_triangle_in) cap_d = triangle_in;
    if (cap_valid_q && cull_c && (culled_q != 16'hFFFF))
      culled_d = 16'(culled_q + 16'd1);
    if (cap_valid_q && !cull_c && fifo_full && !pop_c && (dropped_q != 16'hFFFF))
      dropped_d = 16'(dropped_q + 16'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q          <= '0;
      cap_valid_q    <= 1'b0;
      done_pending_q <= 1'b0;
      done_q         <= 1'b0;
      culled_q       <= '0;
      dropped_q      <= '0;
    end else begin
      cap_q          <= cap_d;
      cap_valid_q    <= cap_valid_d;
      done_pending_q <= done_pending_d;
      done_q         <= done_d;
      culled_q       <= culled_d;
      dropped_q      <= dropped_d;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .wdata_i (wentry_c),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_c        = entry_t'(fifo_rdata);
  assign out_triangle  = head_c.triangle;
  assign out_bbox      = head_c.bbox;
  assign out_valid     = !fifo_empty;
  assign done_out      = done_q;
  assign culled_count  = culled_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_triangle_setup_fifo.sv
// Directed bench for triangle_setup_fifo: bbox/cull table plus overflow, done and reset sequences.
module tb_triangle_setup_fifo;
  import graphics_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  triangle_t   triangle_in;
  logic        new_triangle_in;
  logic        done_in;
  triangle_t   out_triangle;
  bbox_t       out_bbox;
  logic        out_valid;
  logic        out_ready;
  logic        done_out;
  logic [15:0] culled_count;
  logic [15:0] dropped_count;

  int total = 0;
  int bad   = 0;

  triangle_setup_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .triangle_in     (triangle_in),
    .new_triangle_in (new_triangle_in),
    .done_in         (done_in),
    .out_triangle    (out_triangle),
    .out_bbox        (out_bbox),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .done_out        (done_out),
    .culled_count    (culled_count),
    .dropped_count   (dropped_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    triangle_t trg;
    logic      exp_valid;
    bbox_t     exp_bbox;
  } vec_t;

  vec_t vecs [8];

  function automatic triangle_t mk(input int color, input int x1, input int y1,
                                   input int x2, input int y2, input int x3,
                                   input int y3, input int depth);
    triangle_t t;
    t.color = 16'(color);
    t.p1x = 16'(x1); t.p1y = 16'(y1);
    t.p2x = 16'(x2); t.p2y = 16'(y2);
    t.p3x = 16'(x3); t.p3y = 16'(y3);
    t.depth = 16'(depth);
    return t;
  endfunction

  function automatic bbox_t mkb(input int xmin, input int xmax, input int ymin, input int ymax);
    bbox_t b;
    b.xmin = 16'(xmin); b.xmax = 16'(xmax);
    b.ymin = 16'(ymin); b.ymax = 16'(ymax);
    return b;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " out_valid"},    192'(out_valid), 192'(0));
    chk({tag, " out_triangle"}, 192'(out_triangle), 192'(0));
    chk({tag, " out_bbox"},     192'(out_bbox), 192'(0));
    chk({tag, " done_out"},     192'(done_out), 192'(0));
    chk({tag, " culled"},       192'(culled_count), 192'(0));
    chk({tag, " dropped"},      192'(dropped_count), 192'(0));
  endtask

  int exp_culled;
  int exp_q [$];

  initial begin
    rst = 1'b0;
    triangle_in = '0;
    new_triangle_in = 1'b0;
    done_in = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{mk(16'hF800, 10, 20, -5, 40, 30, -7, 100), 1'b1, mkb(-5, 30, -7, 40)};
    vecs[1] = '{mk(16'h07E0, -300, 0, 500, 10, 0, -200, 5), 1'b1, mkb(-160, 159, -120, 10)};
    vecs[2] = '{mk(16'h001F, 200, 0, 250, 5, 170, -3, 9), 1'b0, mkb(0, 0, 0, 0)};
    vecs[3] = '{mk(16'h1111, 160, 0, 160, 1, 170, 2, 1), 1'b0, mkb(0, 0, 0, 0)};
    vecs[4] = '{mk(16'h2222, 159, 119, 159, 119, 159, 119, 2), 1'b1, mkb(159, 159, 119, 119)};
    vecs[5] = '{mk(16'h3333, -10, -121, 0, -130, 5, -200, 3), 1'b0, mkb(0, 0, 0, 0)};
    vecs[6] = '{mk(16'h4444, -160, -120, -161, -125, -170, -120, 4), 1'b1, mkb(-160, -160, -120, -120)};
    vecs[7] = '{mk(16'h5555, 0, 120, 5, 130, -5, 200, 6), 1'b0, mkb(0, 0, 0, 0)};

    #12;
    check_all_zero("reset");
    tick;
    rst = 1'b1;
    tick;

    // Table: one triangle at a time, checked two edges after the strobe.
    exp_culled = 0;
    for (int i = 0; i < 8; i++) begin
      triangle_in = vecs[i].trg;
      new_triangle_in = 1'b1;
      tick;
      new_triangle_in = 1'b0;
      chk($sformatf("v%0d early_valid", i), 192'(out_valid), 192'(0));
      tick;
      if (!vecs[i].exp_valid) exp_culled++;
      chk($sformatf("v%0d out_valid", i), 192'(out_valid), 192'(vecs[i].exp_valid));
      chk($sformatf("v%0d culled", i), 192'(culled_count), 192'(exp_culled));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d bbox", i), 192'(out_bbox), 192'(vecs[i].exp_bbox));
        chk($sformatf("v%0d triangle", i), 192'(out_triangle), 192'(vecs[i].trg));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk($sformatf("v%0d emptied", i), 192'(out_valid), 192'(0));
      end
    end

    // Overflow: 20 back-to-back strobes into a 16-deep FIFO with no reads.
    for (int i = 0; i < 20; i++) begin
      triangle_in = mk(i, 1, 1, 2, 2, 3, 3, i);
      new_triangle_in = 1'b1;
      tick;
    end
    new_triangle_in = 1'b0;
    tick;
    chk("ovf dropped", 192'(dropped_count), 192'(4));
    chk("ovf culled", 192'(culled_count), 192'(exp_culled));
    chk("ovf head", 192'(out_triangle.color), 192'(0));
    chk("ovf head_bbox", 192'(out_bbox), 192'(mkb(1, 3, 1, 3)));

    // Full plus pop: the write lands in the same cycle as a pop.
    triangle_in = mk(100, 1, 1, 2, 2, 3, 3, 0);
    new_triangle_in = 1'b1;
    tick;
    new_triangle_in = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("fullpop dropped", 192'(dropped_count), 192'(4));
    chk("fullpop head", 192'(out_triangle.color), 192'(1));
    tick;
    chk("hold head", 192'(out_triangle.color), 192'(1));

    for (int i = 1; i < 16; i++) exp_q.push_back(i);
    exp_q.push_back(100);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d valid", k), 192'(out_valid), 192'(1));
      chk($sformatf("drain%0d color", k), 192'(out_triangle.color), 192'(exp_q[k]));
      out_ready = 1'b1;
      tick;
    end
    out_ready = 1'b0;
    chk("drain empty", 192'(out_valid), 192'(0));
    chk("drain dropped", 192'(dropped_count), 192'(4));

    // Done coinciding with the final triangle while the consumer stalls.
    triangle_in = mk(16'h0ABC, 0, 0, 1, 1, 2, 2, 7);
    new_triangle_in = 1'b1;
    done_in = 1'b1;
    tick;
    new_triangle_in = 1'b0;
    done_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("done stalled%0d", k), 192'(done_out), 192'(0));
    end
    chk("done head", 192'(out_triangle.color), 192'(16'h0ABC));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("done after_pop valid", 192'(out_valid), 192'(0));
    chk("done after_pop", 192'(done_out), 192'(0));
    tick;
    chk("done pulse", 192'(done_out), 192'(1));
    tick;
    chk("done single", 192'(done_out), 192'(0));
    tick;
    chk("done stays low", 192'(done_out), 192'(0));

    // Reset mid-burst: outputs drop without a clock edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      triangle_in = (i == 2) ? mk(9, 500, 0, 600, 0, 700, 0, 0) : mk(i + 50, 0, 0, 4, 4, 8, 8, 0);
      new_triangle_in = 1'b1;
      tick;
    end
    chk("burst valid", 192'(out_valid), 192'(1));
    chk("burst culled", 192'(culled_count), 192'(exp_culled + 1));
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    new_triangle_in = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    tick;
    chk("post_rst lost", 192'(out_valid), 192'(0));
    chk("post_rst culled", 192'(culled_count), 192'(0));

    triangle_in = vecs[0].trg;
    new_triangle_in = 1'b1;
    tick;
    new_triangle_in = 1'b0;
    tick;
    chk("post_rst valid", 192'(out_valid), 192'(1));
    chk("post_rst bbox", 192'(out_bbox), 192'(vecs[0].exp_bbox));
    chk("post_rst dropped", 192'(dropped_count), 192'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
